mio_bus_responder: RTL and testbench
====================================

// Module: mio_bus_responder
// PURPOSE
//  Slave end of the CPU memory/IO bus. Answers MemRead/MemWrite requests from the multi-cycle
//  controller with a single-cycle MIO_ready pulse. Routes each access to block RAM (wait states)
//  or to polled IO registers: LED, switches, button status/data and a timer.
//  Sits between the CPU datapath and the RAM/board IO.
// PARAMETERS
//  RAM_AW   10     RAM word-address width (RAM = 2^RAM_AW words at byte addr 0)
//  RAM_LAT  2      RAM read latency in cycles (>=1): ram_dout valid RAM_LAT cycles after ram_addr
//  TIMER_W  32     timer width (<=32, zero-extended on read)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  reset      in   1   synchronous, active-high
//  CPU_MIO    in   1   bus request qualifier
//  MemRead    in   1   read request, held until MIO_ready seen
//  MemWrite   in   1   write request, held until MIO_ready seen
//  Addr_in    in   32  byte address; [1:0] ignored
//  Data_in    in   32  CPU write data
//  Data_out   out  32  read data, valid only while MIO_ready=1
//  MIO_ready  out  1   one-cycle completion pulse
//  bus_err    out  1   one-cycle pulse: unmapped access, or MemRead&MemWrite together
//  ram_addr   out  RAM_AW  RAM word address (registered)
//  ram_din    out  32  RAM write data
//  ram_we     out  1   RAM write strobe
//  ram_dout   in   32  RAM read data
//  sw_in      in   16  board switches (asynchronous)
//  btn_in     in   4   board buttons (asynchronous)
//  led_out    out  16  LED register
// BEHAVIOUR
//  - Reset values: Data_out=0, MIO_ready=0, bus_err=0, ram_we=0, ram_addr=0, led_out=0.
//    Timer=0, btn status=0, btn data=0; FSM returns to IDLE. Reset mid-access aborts it:
//    no ready, no write.
//  - req = CPU_MIO & (MemRead|MemWrite). If both MemRead and MemWrite are set, the access is a write
//    and bus_err pulses with MIO_ready.
//  - Map: Addr_in[31:28]!=4'hF -> RAM if Addr_in[31:RAM_AW+2]==0, else unmapped.
//    0xF0000000 LED RW [15:0] | 0xF0000004 SW RO [15:0] | 0xF0000008 BTN_STATUS RO
//    (bit0 valid, bit1 overrun) | 0xF000000C BTN_DATA RO [3:0] | 0xF0000010 TIMER RW (write clears).
//    Other 0xF addresses are unmapped.
//  - Unmapped: read data=0, write ignored, bus_err=1 in the RESP cycle. Writes to RO regs are ignored
//    and raise no error.
//  - FSM IDLE -> (RAM read) RAM_WAIT -> RESP -> TURN -> IDLE; IO, write and unmapped: IDLE -> RESP.
//    IDLE: on req, latch addr/data/type; ram_addr <= word addr.
//    RAM_WAIT: count RAM_LAT cycles, then capture ram_dout.
//    RESP: MIO_ready=1 and Data_out valid for exactly 1 cycle. Writes commit only here:
//    ram_we=1 for RAM, or the register update for IO.
//    TURN: 1 cycle, req ignored. This prevents a double response while the CPU drops its request.
//  - Latency from the cycle req is first seen in IDLE: RAM read ready at +RAM_LAT+1. All other
//    accesses ready at +1. Back-to-back: next req accepted 2 cycles after the ready cycle.
//  - If req drops in RAM_WAIT: go to IDLE with no ready.
//  - Data_out = 0 in every cycle except RESP.
//  - Buttons: 2-flop synchroniser, then rising-edge detect on any bit.
//    On an edge: BTN_DATA <= synced btn; valid <= 1; overrun <= 1 if valid was already 1.
//  - A BTN_STATUS read returns the pre-clear value and clears valid/overrun in RESP.
//    If an edge arrives in that same cycle, the edge wins: valid=1, overrun=0, data updated.
//  - sw_in uses a 2-flop synchroniser; reads return the synced value.
//  - Timer increments every cycle and wraps at 2^TIMER_W. A write in RESP forces it to 0; the write
//    wins over the increment.
// TESTING
//  - RAM_LAT=2: write 0x12345678 to 0x40, then read 0x40 -> ready 3 cycles after req, Data_out=0x12345678.
//    ram_we high exactly 1 cycle.
//  - Held request: req stays high 2 cycles past ready -> exactly one MIO_ready pulse.
//    Back-to-back reads -> second ready no earlier than 2 cycles after the first.
//  - Write 0xA5A5 to 0xF0000000 -> led_out=0xA5A5 after RESP.
//    Read 0xF0000004 with sw_in=0x00FF -> 0x000000FF at ready+1.
//  - Press btn=4'b0100 twice, no read -> STATUS=0x3, DATA=0x4; second STATUS read -> 0x0.
//    Press coinciding with a STATUS read -> STATUS becomes 0x1.
//  - Read 0x00100000 (RAM_AW=10) -> Data_out=0, bus_err=1, MIO_ready=1.
//    MemRead&MemWrite together -> write performed, bus_err=1.
//  - Assert reset during RAM_WAIT -> no ready, all outputs at reset values.
//    Write to TIMER -> next read returns a small count (<4).

Source files
------------

// File: rtl/mio_bus_responder.sv
// Slave end of the CPU memory/IO bus: decodes each request to block RAM (with wait states) or
// polled IO registers and answers with a single-cycle MIO_ready pulse.
module mio_bus_responder #(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned TIMER_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr_in,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Data_out,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    input  logic [3:0]        btn_in,
    output logic [15:0]       led_out
);

    localparam int unsigned CntW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(RAM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRamWait, StResp, StTurn} state_e;
    typedef enum logic [2:0] {RgRam, RgLed, RgSw, RgBtnSt, RgBtnDat, RgTimer, RgNone} region_e;

    state_e             state_q, state_d;
    region_e            region, region_q, region_d;
    logic               wr_q, wr_d;
    logic               both_q, both_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [RAM_AW-1:0]  ram_addr_q, ram_addr_d;
    logic [15:0]        led_q, led_d;
    logic [15:0]        sw_s1_q, sw_s2_q;
    logic [3:0]         btn_s1_q, btn_s2_q, btn_prev_q;
    logic               btn_valid_q, btn_valid_d;
    logic               btn_ovr_q, btn_ovr_d;
    logic [3:0]         btn_data_q, btn_data_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic req, resp, wr_commit, btn_edge, btn_clr;
    logic unused_addr;

    assign unused_addr = ^Addr_in[1:0];
    assign req         = CPU_MIO & (MemRead | MemWrite);
    assign resp        = (state_q == StResp);
    assign wr_commit   = resp & wr_q;
    assign btn_edge    = |(btn_s2_q & ~btn_prev_q);
    assign btn_clr     = resp && !wr_q && (region_q == RgBtnSt);

    always_comb begin
        region = RgNone;
        if (Addr_in[31:28] != 4'hF) begin
            if (Addr_in[31:RAM_AW+2] == '0) region = RgRam;
        end else begin
            case (Addr_in[27:2])
                26'h0:   region = RgLed;
                26'h1:   region = RgSw;
                26'h2:   region = RgBtnSt;
                26'h3:   region = RgBtnDat;
                26'h4:   region = RgTimer;
                default: region = RgNone;
            endcase
        end
    end

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            region_q    <= RgNone;
            wr_q        <= 1'b0;
            both_q      <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            led_q       <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_prev_q  <= '0;
            btn_valid_q <= 1'b0;
            btn_ovr_q   <= 1'b0;
            btn_data_q  <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            wr_q        <= wr_d;
            both_q      <= both_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            led_q       <= led_d;
            sw_s1_q     <= sw_in;
            sw_s2_q     <= sw_s1_q;
            btn_s1_q    <= btn_in;
            btn_s2_q    <= btn_s1_q;
            btn_prev_q  <= btn_s2_q;
            btn_valid_q <= btn_valid_d;
            btn_ovr_q   <= btn_ovr_d;
            btn_data_q  <= btn_data_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (req) state_d = (region == RgRam && !MemWrite) ? StRamWait : StResp;
            StRamWait: begin
                if (!req) state_d = StIdle;
                else if (cnt_q == LastCnt) state_d = StResp;
            end
            StResp:    state_d = StTurn;
            StTurn:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        region_d   = region_q;
        wr_d       = wr_q;
        both_d     = both_q;
        wdata_d    = wdata_q;
        ram_addr_d = ram_addr_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        if (state_q == StIdle && req) begin
            region_d   = region;
            wr_d       = MemWrite;
            both_d     = MemRead & MemWrite;
            wdata_d    = Data_in;
            ram_addr_d = Addr_in[RAM_AW+1:2];
            cnt_d      = '0;
        end
        if (state_q == StRamWait) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) rdata_d = ram_dout;
        end
    end

    always_comb begin
        led_d       = led_q;
        timer_d     = timer_q + TIMER_W'(1);
        btn_valid_d = btn_valid_q;
        btn_ovr_d   = btn_ovr_q;
        btn_data_d  = btn_data_q;
        if (wr_commit && region_q == RgLed) led_d = wdata_q[15:0];
        if (wr_commit && region_q == RgTimer) timer_d = '0;
        if (btn_clr) begin
            btn_valid_d = 1'b0;
            btn_ovr_d   = 1'b0;
        end
        // A new edge beats a same-cycle status clear.
        if (btn_edge) begin
            btn_data_d  = btn_s2_q;
            btn_valid_d = 1'b1;
            btn_ovr_d   = btn_clr ? 1'b0 : (btn_valid_q | btn_ovr_q);
        end
    end

    // Outputs are masked by reset so an aborted access can neither respond nor write.
    always_comb begin
        MIO_ready = 1'b0;
        bus_err   = 1'b0;
        ram_we    = 1'b0;
        Data_out  = '0;
        if (resp && !reset) begin
            MIO_ready = 1'b1;
            bus_err   = both_q || (region_q == RgNone);
            ram_we    = wr_q && (region_q == RgRam);
            if (!wr_q) begin
                case (region_q)
                    RgRam:    Data_out = rdata_q;
                    RgLed:    Data_out[15:0] = led_q;
                    RgSw:     Data_out[15:0] = sw_s2_q;
                    RgBtnSt:  Data_out[1:0] = {btn_ovr_q, btn_valid_q};
                    RgBtnDat: Data_out[3:0] = btn_data_q;
                    RgTimer:  Data_out[TIMER_W-1:0] = timer_q;
                    default:  Data_out = '0;
                endcase
            end
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = wdata_q;
    assign led_out  = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: a vector table for single accesses plus hand-written
// sequences for held requests, buttons, timer and reset.
`timescale 1ns/1ps
module tb_mio_bus_responder;

    localparam int unsigned RAM_AW  = 10;
    localparam int unsigned RAM_LAT = 2;

    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_BST  = 32'hF000_0008;
    localparam logic [31:0] A_BDAT = 32'hF000_000C;
    localparam logic [31:0] A_TMR  = 32'hF000_0010;

    logic              clk = 1'b0;
    logic              reset;
    logic              CPU_MIO, MemRead, MemWrite;
    logic [31:0]       Addr_in, Data_in, Data_out;
    logic              MIO_ready, bus_err;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_we;
    logic [31:0]       ram_dout;
    logic [15:0]       sw_in;
    logic [3:0]        btn_in;
    logic [15:0]       led_out;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_pulses = 0;
    int we_pulses  = 0;

    logic [31:0] mem [1024];

    mio_bus_responder #(
        .RAM_AW (RAM_AW),
        .RAM_LAT(RAM_LAT),
        .TIMER_W(32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .CPU_MIO  (CPU_MIO),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .MIO_ready(MIO_ready),
        .bus_err  (bus_err),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .sw_in    (sw_in),
        .btn_in   (btn_in),
        .led_out  (led_out)
    );

    always #5 clk = ~clk;

    // Block RAM model: registered read of the registered address.
    initial for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | i;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (MIO_ready) rdy_pulses <= rdy_pulses + 1;
        if (ram_we) we_pulses <= we_pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [15:0] sw;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drop_req();
        CPU_MIO  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    // Issue one access from IDLE, wait for ready, release and return two cycles later.
    task automatic bus_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] dout, output logic err,
                           output int lat);
        CPU_MIO  = 1'b1;
        MemRead  = rd;
        MemWrite = wr;
        Addr_in  = addr;
        Data_in  = wd;
        lat  = 0;
        dout = '0;
        err  = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (MIO_ready) begin
                lat  = i;
                dout = Data_out;
                err  = bus_err;
            end
        end
        drop_req();
        if (lat == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn timeout: got no ready, expected ready within 20 cycles");
        end
        @(negedge clk);
        check("post-ready MIO_ready", {31'b0, MIO_ready}, 32'h0);
        check("post-ready Data_out", Data_out, 32'h0);
        @(negedge clk);
    endtask

    logic [31:0] d, t0;
    logic        e;
    int          lat, p0, w0, gap;

    initial begin
        reset = 1'b1;
        drop_req();
        Addr_in = '0;
        Data_in = '0;
        sw_in   = 16'h00FF;
        btn_in  = 4'h0;

        //              rd    wr    addr          wd            sw       data          err lat we led
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 16'h00FF, 32'h0,          1'b0, 1, 1, 16'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         16'h00FF, 32'h1234_5678,  1'b0, 3, 0, 16'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0042, 32'h0,         16'h00FF, 32'h1234_5678,  1'b0, 3, 0, 16'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         16'h00FF, 32'hC0DE_0011,  1'b0, 3, 0, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         16'h00FF, 32'hC0DE_03FF,  1'b0, 3, 0, 16'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         16'h00FF, 32'h0,          1'b1, 1, 0, 16'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0010_0000, 32'h0,         16'h00FF, 32'h0,          1'b1, 1, 0, 16'h0};
        vecs[7]  = '{1'b1, 1'b0, A_BST,         32'h0,         16'h00FF, 32'h0,          1'b0, 1, 0, 16'h0};
        vecs[8]  = '{1'b0, 1'b1, A_LED,         32'h1234_A5A5, 16'h00FF, 32'h0,          1'b0, 1, 0, 16'hA5A5};
        vecs[9]  = '{1'b1, 1'b0, A_LED,         32'h0,         16'h00FF, 32'h0000_A5A5,  1'b0, 1, 0, 16'hA5A5};
        vecs[10] = '{1'b1, 1'b0, A_SW,          32'h0,         16'h00FF, 32'h0000_00FF,  1'b0, 1, 0, 16'hA5A5};
        vecs[11] = '{1'b0, 1'b1, A_SW,          32'hFFFF,      16'h1234, 32'h0,          1'b0, 1, 0, 16'hA5A5};
        vecs[12] = '{1'b1, 1'b0, A_SW,          32'h0,         16'h1234, 32'h0000_1234,  1'b0, 1, 0, 16'hA5A5};
        vecs[13] = '{1'b0, 1'b1, 32'hF000_0014, 32'h1111,      16'h1234, 32'h0,          1'b1, 1, 0, 16'hA5A5};
        vecs[14] = '{1'b1, 1'b0, 32'hF000_0014, 32'h0,         16'h1234, 32'h0,          1'b1, 1, 0, 16'hA5A5};
        vecs[15] = '{1'b1, 1'b1, A_LED,         32'h5A5A,      16'h1234, 32'h0,          1'b1, 1, 0, 16'h5A5A};
        vecs[16] = '{1'b1, 1'b0, A_LED,         32'h0,         16'h1234, 32'h0000_5A5A,  1'b0, 1, 0, 16'h5A5A};
        vecs[17] = '{1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 16'h1234, 32'h0,          1'b1, 1, 1, 16'h5A5A};
        vecs[18] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         16'h1234, 32'hDEAD_BEEF,  1'b0, 3, 0, 16'h5A5A};

        repeat (3) @(negedge clk);
        check("reset Data_out", Data_out, 32'h0);
        check("reset MIO_ready", {31'b0, MIO_ready}, 32'h0);
        check("reset bus_err", {31'b0, bus_err}, 32'h0);
        check("reset ram_we", {31'b0, ram_we}, 32'h0);
        check("reset ram_addr", {22'b0, ram_addr}, 32'h0);
        check("reset led_out", {16'b0, led_out}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            sw_in = vecs[i].sw;
            repeat (3) @(negedge clk);
            w0 = we_pulses;
            bus_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, d, e, lat);
            check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d bus_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d ram_we pulses", i), 32'(we_pulses - w0), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d led_out", i), {16'b0, led_out}, {16'b0, vecs[i].exp_led});
        end

        // Request held two cycles past ready yields one pulse.
        p0 = rdy_pulses;
        CPU_MIO = 1'b1; MemRead = 1'b1; Addr_in = A_SW;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (MIO_ready) lat = i;
        end
        repeat (2) @(negedge clk);
        drop_req();
        repeat (4) @(negedge clk);
        check("held req pulse count", 32'(rdy_pulses - p0), 32'd1);

        // Continuously held request: second ready three cycles after the first.
        CPU_MIO = 1'b1; MemRead = 1'b1; Addr_in = A_SW;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (MIO_ready) lat = i;
        end
        gap = 0;
        for (int i = 1; i <= 20 && gap == 0; i++) begin
            @(negedge clk);
            if (MIO_ready) gap = i;
        end
        drop_req();
        check("back-to-back gap", 32'(gap), 32'd3);
        repeat (2) @(negedge clk);

        // Request dropped during RAM_WAIT: no response.
        p0 = rdy_pulses;
        CPU_MIO = 1'b1; MemRead = 1'b1; Addr_in = 32'h40;
        @(negedge clk);
        drop_req();
        repeat (5) @(negedge clk);
        check("dropped req pulses", 32'(rdy_pulses - p0), 32'd0);

        // Two presses without a read: valid and overrun.
        for (int k = 0; k < 2; k++) begin
            btn_in = 4'b0100;
            repeat (4) @(negedge clk);
            btn_in = 4'b0000;
            repeat (4) @(negedge clk);
        end
        bus_txn(1'b1, 1'b0, A_BST, 32'h0, d, e, lat);
        check("btn status after 2 presses", d, 32'h3);
        bus_txn(1'b1, 1'b0, A_BDAT, 32'h0, d, e, lat);
        check("btn data", d, 32'h4);
        bus_txn(1'b1, 1'b0, A_BST, 32'h0, d, e, lat);
        check("btn status after clear", d, 32'h0);

        // Edge lands in the RESP cycle of a status read.
        @(negedge clk);
        btn_in = 4'b0001;
        @(negedge clk);
        bus_txn(1'b1, 1'b0, A_BST, 32'h0, d, e, lat);
        check("btn status pre-clear value", d, 32'h0);
        bus_txn(1'b1, 1'b0, A_BST, 32'h0, d, e, lat);
        check("btn status edge wins", d, 32'h1);
        bus_txn(1'b1, 1'b0, A_BDAT, 32'h0, d, e, lat);
        check("btn data after edge", d, 32'h1);
        btn_in = 4'b0000;

        // Timer write clears it; reads then track the cycle count.
        bus_txn(1'b0, 1'b1, A_TMR, 32'hFFFF_FFFF, d, e, lat);
        bus_txn(1'b1, 1'b0, A_TMR, 32'h0, t0, e, lat);
        check("timer small after clear", {31'b0, (t0 < 32'd4)}, 32'h1);
        bus_txn(1'b1, 1'b0, A_TMR, 32'h0, d, e, lat);
        check("timer increment between reads", d - t0, 32'd3);

        // Reset during RAM_WAIT aborts the access.
        p0 = rdy_pulses;
        CPU_MIO = 1'b1; MemRead = 1'b1; Addr_in = 32'h0000_0084;
        @(negedge clk);
        reset = 1'b1;
        drop_req();
        @(negedge clk);
        check("abort Data_out", Data_out, 32'h0);
        check("abort MIO_ready", {31'b0, MIO_ready}, 32'h0);
        check("abort bus_err", {31'b0, bus_err}, 32'h0);
        check("abort ram_we", {31'b0, ram_we}, 32'h0);
        check("abort ram_addr", {22'b0, ram_addr}, 32'h0);
        check("abort led_out", {16'b0, led_out}, 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort no ready", 32'(rdy_pulses - p0), 32'd0);

        bus_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, d, e, lat);
        check("after reset RAM read", d, 32'h1234_5678);
        check("after reset RAM latency", 32'(lat), 32'd3);
        bus_txn(1'b1, 1'b0, A_LED, 32'h0, d, e, lat);
        check("after reset LED read", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
